// File: rtl/bfup_pkg.sv
// rtl/bfup_pkg.sv - shared constants and helpers for the brainfuck_uP port bridge
package bfup_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] FIFO_RST_DATA = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bfup_byte_fifo.sv
// rtl/bfup_byte_fifo.sv - first-word-fall-through byte FIFO with internal full/empty guards
module bfup_byte_fifo
  import bfup_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic [CW-1:0]     cnt;
  logic              popEff;
  logic              pushEff;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign popEff  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
  assign pushEff = push && (!full || popEff);
  assign count   = cnt;
  assign head    = empty ? FIFO_RST_DATA : mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (pushEff) wrPtr <= wrPtr + AW'(1);
      if (popEff)  rdPtr <= rdPtr + AW'(1);
      cnt <= cnt + CW'(pushEff) - CW'(popEff);
    end
  end

  always_ff @(posedge clk) begin
    if (pushEff) mem[wrPtr] <= push_data;
  end

endmodule

// File: rtl/bfup_port_bridge.sv
// rtl/bfup_port_bridge.sv - CPU port responder bridging portRD/portWR to host rx/tx byte streams
// Optional sticky error flags and FIFO counts when BFUP_PORT_STATS_EN is defined.
module bfup_port_bridge
  import bfup_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic              bfup_clk,
  input  logic              reset,
  input  logic              portRD,
  output logic [BYTE_W-1:0] inPort,
  output logic              incoming,
  input  logic              portWR,
  input  logic [BYTE_W-1:0] outPort,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
`ifdef BFUP_PORT_STATS_EN
  ,
  input  logic              stat_clr,
  output logic              err_under,
  output logic              err_over,
  output logic [clog2(IN_DEPTH):0]  in_count,
  output logic [clog2(OUT_DEPTH):0] out_count
`endif
);

  logic rdQ;
  logic wrQ;
  logic rdAcc;
  logic wrAcc;
  logic inEmpty;
  logic inFull;
  logic outEmpty;
  logic outFull;
  logic txPop;
  logic rxPush;
  logic [clog2(IN_DEPTH):0]  inCount;
  logic [clog2(OUT_DEPTH):0] outCount;

  // One access per rising request level, regardless of how long the CPU holds it.
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      rdQ <= 1'b0;
      wrQ <= 1'b0;
    end else begin
      rdQ <= portRD;
      wrQ <= portWR;
    end
  end

  assign rdAcc    = portRD && !rdQ;
  assign wrAcc    = portWR && !wrQ;
  assign rx_ready = !inFull;
  assign rxPush   = rx_valid && rx_ready;
  assign incoming = !inEmpty;
  assign tx_valid = !outEmpty;
  assign txPop    = tx_valid && tx_ready;

  bfup_byte_fifo #(.DEPTH(IN_DEPTH)) u_inFifo (
    .clk       (bfup_clk),
    .rst_n     (reset),
    .push      (rxPush),
    .push_data (rx_data),
    .pop       (rdAcc),
    .head      (inPort),
    .empty     (inEmpty),
    .full      (inFull),
    .count     (inCount)
  );

  bfup_byte_fifo #(.DEPTH(OUT_DEPTH)) u_outFifo (
    .clk       (bfup_clk),
    .rst_n     (reset),
    .push      (wrAcc),
    .push_data (outPort),
    .pop       (txPop),
    .head      (tx_data),
    .empty     (outEmpty),
    .full      (outFull),
    .count     (outCount)
  );

`ifdef BFUP_PORT_STATS_EN
  logic underflow;
  logic overflow;
  logic errUnderQ;
  logic errOverQ;

  assign underflow = rdAcc && inEmpty;
  assign overflow  = wrAcc && outFull && !txPop;

  // A new event in the clear cycle keeps the flag set.
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      errUnderQ <= 1'b0;
      errOverQ  <= 1'b0;
    end else begin
      if (underflow)     errUnderQ <= 1'b1;
      else if (stat_clr) errUnderQ <= 1'b0;
      if (overflow)      errOverQ  <= 1'b1;
      else if (stat_clr) errOverQ  <= 1'b0;
    end
  end

  assign err_under = errUnderQ;
  assign err_over  = errOverQ;
  assign in_count  = inCount;
  assign out_count = outCount;
`else
  logic unusedStats;
  assign unusedStats = &{1'b0, outFull, inCount, outCount};
`endif

endmodule

// File: tb/tb_bfup_port_bridge.sv
// tb/tb_bfup_port_bridge.sv - randomized scoreboard bench for bfup_port_bridge
module tb_bfup_port_bridge;

  localparam int IN_DEPTH  = 16;
  localparam int OUT_DEPTH = 16;
  localparam int NCYC      = 2400;
  localparam int RST_CYC   = 1200;

  logic       bfup_clk = 1'b0;
  logic       reset;
  logic       portRD, portWR;
  logic [7:0] inPort, outPort;
  logic       incoming;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
`ifdef BFUP_PORT_STATS_EN
  logic       stat_clr, err_under, err_over;
  logic [4:0] in_count, out_count;
`endif

  always #5 bfup_clk = ~bfup_clk;

  bfup_port_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .bfup_clk  (bfup_clk),
    .reset     (reset),
    .portRD    (portRD),
    .inPort    (inPort),
    .incoming  (incoming),
    .portWR    (portWR),
    .outPort   (outPort),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
`ifdef BFUP_PORT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .err_under (err_under),
    .err_over  (err_over),
    .in_count  (in_count),
    .out_count (out_count)
`endif
  );

  typedef struct {
    logic       incoming;
    logic       rxReady;
    logic       txValid;
    logic [7:0] inPort;
    logic [7:0] txData;
    logic       errU;
    logic       errO;
    int         inCnt;
    int         outCnt;
  } stat_t;

  stat_t      expStat[$];
  logic [7:0] expRd[$];
  logic [7:0] expTx[$];
  logic [7:0] inQ[$];
  logic [7:0] outQ[$];

  int   checks = 0;
  int   errors = 0;
  bit   run = 0;
  logic monPrevRd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a cycle, a read, or a tx beat.
  always @(negedge bfup_clk) begin
    stat_t s;
    if (run) begin
      if (expStat.size() == 0) chk("stat_queue_empty", 0, 1);
      else begin
        s = expStat.pop_front();
        chk("incoming", incoming, s.incoming);
        chk("rx_ready", rx_ready, s.rxReady);
        chk("tx_valid", tx_valid, s.txValid);
        chk("inPort_head", inPort, s.inPort);
        chk("tx_data_head", tx_data, s.txData);
`ifdef BFUP_PORT_STATS_EN
        chk("err_under", err_under, s.errU);
        chk("err_over", err_over, s.errO);
        chk("in_count", in_count, s.inCnt);
        chk("out_count", out_count, s.outCnt);
`endif
      end
      if (reset && portRD && !monPrevRd) begin
        if (expRd.size() == 0) chk("rd_queue_empty", 0, 1);
        else chk("rd_byte", inPort, expRd.pop_front());
      end
      if (reset && tx_valid && tx_ready) begin
        if (expTx.size() == 0) chk("tx_queue_empty", 0, 1);
        else chk("tx_byte", tx_data, expTx.pop_front());
      end
    end
    monPrevRd = reset ? portRD : 1'b0;
  end

  initial begin
    bit   prevRd, prevWr, mErrU, mErrO, rdAcc, wrAcc, rxPush, txPop, clr;
    int   inPre, outPre, phase, rxP, rdP, wrP, txP;
    stat_t s;

    reset = 1'b1;
    portRD = 0; portWR = 0; outPort = 0; rx_data = 0; rx_valid = 0; tx_ready = 0;
`ifdef BFUP_PORT_STATS_EN
    stat_clr = 0;
`endif
    #2 reset = 1'b0;
    repeat (3) @(posedge bfup_clk);
    #1;
    chk("rst_inPort", inPort, 8'h00);
    chk("rst_incoming", incoming, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b1;

    prevRd = 0; prevWr = 0; mErrU = 0; mErrO = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge bfup_clk);
      #1;
      run = 1;
      phase = (cyc / 150) % 4;
      case (phase)
        0: begin rxP = 90; rdP = 20; wrP = 60; txP = 15; end
        1: begin rxP = 30; rdP = 60; wrP = 20; txP = 85; end
        2: begin rxP = 95; rdP = 50; wrP = 60; txP = 50; end
        default: begin rxP = 10; rdP = 70; wrP = 10; txP = 90; end
      endcase
      portRD   = ($urandom_range(99) < rdP);
      portWR   = ($urandom_range(99) < wrP);
      outPort  = 8'($urandom);
      rx_valid = ($urandom_range(99) < rxP);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(99) < txP);
      clr      = ($urandom_range(99) < 3);
`ifdef BFUP_PORT_STATS_EN
      stat_clr = clr;
`endif

      // Reset mid-stream with requests held high through release.
      if (cyc == RST_CYC || cyc == RST_CYC + 1) begin
        portRD = 1; portWR = 1; tx_ready = 0;
      end
      if (cyc == RST_CYC) begin
        reset = 1'b0;
        inQ.delete(); outQ.delete(); expRd.delete(); expTx.delete();
        prevRd = 0; prevWr = 0; mErrU = 0; mErrO = 0;
        s = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0};
        expStat.push_back(s);
        continue;
      end
      reset = 1'b1;

      inPre  = inQ.size();
      outPre = outQ.size();
      s.incoming = (inPre > 0);
      s.rxReady  = (inPre < IN_DEPTH);
      s.txValid  = (outPre > 0);
      s.inPort   = (inPre > 0) ? inQ[0] : 8'h00;
      s.txData   = (outPre > 0) ? outQ[0] : 8'h00;
      s.errU     = mErrU;
      s.errO     = mErrO;
      s.inCnt    = inPre;
      s.outCnt   = outPre;
      expStat.push_back(s);

      rdAcc  = portRD && !prevRd;
      wrAcc  = portWR && !prevWr;
      prevRd = portRD;
      prevWr = portWR;

      rxPush = rx_valid && (inPre < IN_DEPTH);
      if (rdAcc) begin
        expRd.push_back((inPre > 0) ? inQ[0] : 8'h00);
        if (inPre > 0) void'(inQ.pop_front());
      end
      if (rxPush) inQ.push_back(rx_data);

      txPop = (outPre > 0) && tx_ready;
      if (txPop) void'(outQ.pop_front());
      if (wrAcc && (outPre < OUT_DEPTH || txPop)) begin
        outQ.push_back(outPort);
        expTx.push_back(outPort);
      end

      if (rdAcc && inPre == 0) mErrU = 1;
      else if (clr) mErrU = 0;
      if (wrAcc && outPre == OUT_DEPTH && !txPop) mErrO = 1;
      else if (clr) mErrO = 0;
    end

    @(negedge bfup_clk);
    #1;
    run = 0;
    chk("stat_queue_drained", expStat.size(), 0);
    chk("rd_queue_drained", expRd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
